regfile_write_arbiter: RTL
==========================

// Module: regfile_write_arbiter
// PURPOSE
//  Owns the single write port of registerFile (RD/WriteData/RegWrite) and shares it between two writeback requesters.
//  Requester 0 is ALU writeback; requester 1 is load writeback. Each uses a valid/ready handshake.
//  Out of reset, and on request, it first runs a clear sweep that writes zero to every register.
//  Sits between the execute/memory stages and registerFile; the read ports are not touched.
// PARAMETERS
//  DATA_W    64  width of WriteData and of each requester's data
//  ADDR_W    5   register index width
//  NUM_REGS  32  number of registers cleared by the sweep (must equal 2**ADDR_W)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  init_req    in   1       1-cycle pulse: restart the clear sweep
//  req0_valid  in   1       requester 0 has a write pending
//  req0_rd     in   ADDR_W  requester 0 destination register
//  req0_data   in   DATA_W  requester 0 write data
//  req0_ready  out  1       requester 0 write accepted this cycle (combinational)
//  req1_valid  in   1       requester 1 has a write pending
//  req1_rd     in   ADDR_W  requester 1 destination register
//  req1_data   in   DATA_W  requester 1 write data
//  req1_ready  out  1       requester 1 write accepted this cycle (combinational)
//  RegWrite    out  1       write enable to registerFile (registered)
//  RD          out  ADDR_W  write address to registerFile (registered)
//  WriteData   out  DATA_W  write data to registerFile (registered)
//  init_done   out  1       clear sweep complete; arbiter is in RUN (registered)
// BEHAVIOUR
//  Reset values (reset=0): RegWrite=0, RD=0, WriteData=0, init_done=0, state=INIT, sweep cnt=0, rr_ptr=0.
//  States and transitions:
//   - INIT -> RUN: after the write with cnt==NUM_REGS-1.
//   - RUN -> INIT: when init_req=1.
//   - init_req while already in INIT: restarts cnt at 0.
//  INIT:
//   - Each edge registers RegWrite=1, RD=cnt, WriteData=0, then increments cnt.
//   - All NUM_REGS writes appear on consecutive cycles: 32 cycles for registers 0..31.
//   - init_done goes to 1 on the edge after the cnt==31 write, in the same edge that RegWrite drops.
//   - reqN_ready=0 for the whole of INIT.
//  RUN, grant rules:
//   - A transfer happens when reqN_valid && reqN_ready.
//   - At most one grant per cycle.
//   - Only one requester valid: that requester is granted.
//   - Both valid: rr_ptr=0 grants req0, rr_ptr=1 grants req1.
//   - After any grant, rr_ptr <= index of the requester not granted.
//   - readyN=0 when init_req=1. That cycle makes no grant and registers RegWrite=0; next state is INIT.
//  RUN, write-port timing:
//   - The granted rd/data are registered: RD, WriteData, RegWrite=1 are visible 1 cycle after the handshake.
//   - No grant in a cycle: RegWrite=0 next cycle. RD and WriteData hold their previous values.
//  x0 handling:
//   - A write to rd==0 is accepted (ready=1, rr_ptr updates) but registers RegWrite=0.
//   - The sweep is the only source of writes to x0.
//  Other rules:
//   - Back-to-back grants to the same rd go out in grant order; the later grant's data wins.
//   - valid must stay high and rd/data stable until ready; the arbiter does not buffer.
//   - Async reset mid-sweep or mid-RUN drops RegWrite immediately; the sweep restarts from 0 on release.
//  Widths: cnt is ADDR_W+1 bits so the terminal compare does not wrap; no arithmetic on the data path.
// STRUCTURE
//  Package regfile_pkg holds:
//   - ADDR_W, DATA_W, NUM_REGS
//   - X0_ADDR='0
//   - enum arb_state_t {INIT, RUN}
//  One sub-module, rr_arbiter2: inputs req[1:0], en, clk/reset; outputs grant[1:0] (one-hot); owns rr_ptr.
//  Top level: sweep counter, state register, output registers, x0 suppression.
// TESTING
//  1. Reset release, no requests -> RegWrite=1 with RD=0..31 and WriteData=0 on 32 consecutive cycles; init_done=1 the next cycle; reqN_ready=0 throughout.
//  2. RUN, req0 only: rd=5, data=0xDEAD -> req0_ready=1 same cycle; next cycle RegWrite=1, RD=5, WriteData=0xDEAD.
//  3. RUN, both valid for 4 cycles (req0 rd=1, req1 rd=2), rr_ptr=0 -> grants req0,req1,req0,req1; RD sequence 1,2,1,2 lagging by 1 cycle.
//  4. req1 rd=0, data=0x55 -> req1_ready=1; next cycle RegWrite=0; rr_ptr flips to 0.
//  5. init_req pulse while both valid in RUN -> no ready that cycle; full 32-cycle sweep follows; init_done=0 until it completes.
//  6. reset asserted at sweep cnt=10 -> outputs clear immediately; after release the sweep restarts at RD=0.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared sizes, x0 index and FSM states for the regfile write arbiter
package regfile_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] X0_ADDR = '0;

  // Sweep counter carries one extra bit so the terminal compare cannot wrap.
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(NUM_REGS - 1);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback requesters and registerFile write port bundle
interface regfile_write_arbiter_if;

  logic                           init_req;
  logic                           req0_valid;
  logic [regfile_pkg::ADDR_W-1:0] req0_rd;
  logic [regfile_pkg::DATA_W-1:0] req0_data;
  logic                           req0_ready;
  logic                           req1_valid;
  logic [regfile_pkg::ADDR_W-1:0] req1_rd;
  logic [regfile_pkg::DATA_W-1:0] req1_data;
  logic                           req1_ready;
  logic                           RegWrite;
  logic [regfile_pkg::ADDR_W-1:0] RD;
  logic [regfile_pkg::DATA_W-1:0] WriteData;
  logic                           init_done;

  // Requester / control side.
  modport master (
    output init_req,
    output req0_valid, req0_rd, req0_data,
    input  req0_ready,
    output req1_valid, req1_rd, req1_data,
    input  req1_ready,
    input  RegWrite, RD, WriteData, init_done
  );

  // Arbiter side.
  modport slave (
    input  init_req,
    input  req0_valid, req0_rd, req0_data,
    output req0_ready,
    input  req1_valid, req1_rd, req1_data,
    output req1_ready,
    output RegWrite, RD, WriteData, init_done
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// rtl/regfile_write_arbiter_rr_arbiter2.sv - two-way round-robin grant with its own priority pointer
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  always_comb begin
    grant    = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (en) begin
      if (req == 2'b11) begin
        grant = rr_ptr_q ? 2'b10 : 2'b01;
      end else begin
        grant = req;
      end
      // Priority moves to whichever side lost (or was idle) this grant.
      if (|req) begin
        rr_ptr_d = grant[0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the registerFile write port between ALU and load writeback after a clear sweep
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done_q, done_d;

  logic [1:0]        grant;
  logic              arb_en;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_data;

  assign arb_en = (state_q == RUN) && !bus.init_req;

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.req1_valid, bus.req0_valid}),
    .en    (arb_en),
    .grant (grant)
  );

  assign bus.req0_ready = grant[0];
  assign bus.req1_ready = grant[1];

  assign sel_rd   = grant[1] ? bus.req1_rd   : bus.req0_rd;
  assign sel_data = grant[1] ? bus.req1_data : bus.req0_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    regwrite_d = 1'b0;
    rd_d       = rd_q;
    wdata_d    = wdata_q;
    // Done lags the INIT->RUN edge by one cycle so it rises as the last sweep write retires.
    done_d     = arb_en;

    unique case (state_q)
      INIT: begin
        if (bus.init_req) begin
          cnt_d = '0;
        end else begin
          regwrite_d = 1'b1;
          rd_d       = cnt_q[ADDR_W-1:0];
          wdata_d    = '0;
          if (cnt_q == LAST_CNT) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.init_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end else if ((|grant) && (sel_rd != X0_ADDR)) begin
          // x0 grants complete the handshake but never reach the register file.
          regwrite_d = 1'b1;
          rd_d       = sel_rd;
          wdata_d    = sel_data;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      cnt_q      <= '0;
      regwrite_q <= 1'b0;
      rd_q       <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      regwrite_q <= regwrite_d;
      rd_q       <= rd_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
    end
  end

  assign bus.RegWrite  = regwrite_q;
  assign bus.RD        = rd_q;
  assign bus.WriteData = wdata_q;
  assign bus.init_done = done_q;

endmodule
